// File: rtl/phy_rx_lane_merge_if.sv
// Lane-side inputs and merged-stream outputs of the PHY receive lane merger.
interface phy_rx_lane_merge_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] dataIn0, dataIn1, dataIn2, dataIn3;
  logic             validIn0, validIn1, validIn2, validIn3;
  logic             readyOut;
  logic [WIDTH-1:0] dataOut;
  logic             validOut;
  logic [1:0]       laneSel;
  logic [3:0]       overflow;
  logic [3:0]       empty;

  modport slave (
    input  dataIn0, dataIn1, dataIn2, dataIn3,
    input  validIn0, validIn1, validIn2, validIn3, readyOut,
    output dataOut, validOut, laneSel, overflow, empty
  );

  modport master (
    output dataIn0, dataIn1, dataIn2, dataIn3,
    output validIn0, validIn1, validIn2, validIn3, readyOut,
    input  dataOut, validOut, laneSel, overflow, empty
  );
endinterface

// File: rtl/phy_rx_lane_merge.sv
// Buffers four PHY receive lanes in per-lane FIFOs and re-serialises them
// in strict lane order 0..3 onto one byte stream with valid/ready.

module phy_rx_lane_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             ovf_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             ovf_q;
  logic             full, push_ok;

  assign full    = (cnt_q == FULL_CNT);
  // A full lane still accepts a byte when the merger drains it on the same edge.
  assign push_ok = push_i && (!full || pop_i);
  assign cnt_d   = cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_i)   rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
      if (push_i && !push_ok) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push_ok) mem_q[wr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign ovf_o   = ovf_q;
endmodule

module phy_rx_lane_merge #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic              clk_f,
  input  logic              reset,
  phy_rx_lane_merge_if.slave bus
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][WIDTH-1:0] din, head;
  logic [NUM_LANES-1:0]            vin, pop, emp, ovf;

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [1:0]       sel_q, sel_d;
  logic             load;

  assign din = {bus.dataIn3, bus.dataIn2, bus.dataIn1, bus.dataIn0};
  assign vin = {bus.validIn3, bus.validIn2, bus.validIn1, bus.validIn0};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    phy_rx_lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk_i  (clk_f),
      .rst_i  (reset),
      .push_i (vin[g]),
      .data_i (din[g]),
      .pop_i  (pop[g]),
      .head_o (head[g]),
      .empty_o(emp[g]),
      .ovf_o  (ovf[g])
    );
  end

  // Strict ordering: stall on an empty selected lane rather than skipping it.
  assign load = (!valid_q || bus.readyOut) && !emp[sel_q];

  always_comb begin
    pop          = '0;
    pop[sel_q]   = load;
    data_d       = data_q;
    valid_d      = valid_q;
    sel_d        = sel_q;
    if (load) begin
      data_d  = head[sel_q];
      valid_d = 1'b1;
      sel_d   = sel_q + 2'd1;
    end else if (valid_q && bus.readyOut) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_f) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sel_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.dataOut  = data_q;
  assign bus.validOut = valid_q;
  assign bus.laneSel  = sel_q;
  assign bus.overflow = ovf;
  assign bus.empty    = emp;
endmodule
